// File: rtl/sram_1rw1r_scrub_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_1rw1r_scrub_if
// Description : Port bundle for the 1RW+1R scrubbed SRAM (port 0 RW, port 1 R).
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_1rw1r_scrub_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int WMASK_WIDTH = 8
);
  localparam int NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH;

  logic                  csb0;
  logic                  web0;
  logic [NUM_WMASKS-1:0] wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;
  logic                  csb1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] dout1;
  logic                  busy;
  logic                  collision;

  modport master (
    output csb0, web0, wmask0, addr0, din0, csb1, addr1,
    input  dout0, dout1, busy, collision
  );

  modport slave (
    input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
    output dout0, dout1, busy, collision
  );
endinterface
`default_nettype wire

// File: rtl/sram_1rw1r_scrub.sv
`default_nettype none
// ============================================================================
// Module      : sram_1rw1r_scrub
// Description : 1RW+1R synchronous SRAM with post-reset scrub, lane write mask,
//               defined same-address collision behaviour and held outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_1rw1r_scrub #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    RAM_DEPTH      = 1 << ADDR_WIDTH,
  parameter int                    WMASK_WIDTH    = 8,
  parameter int                    READ_LATENCY   = 1,
  parameter int                    COLLISION_MODE = 0,
  parameter int                    SCRUB_EN       = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
  input  logic                clk0,
  input  logic                rst,
  sram_1rw1r_scrub_if.slave   bus
);
  localparam int NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH;
  localparam int IDX_W      = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int PTR_W      = $clog2(RAM_DEPTH + 1);
  localparam logic [PTR_W-1:0]    LAST_PTR  = PTR_W'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  typedef enum logic [0:0] {
    S_SCRUB = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  active, rd0, rd1, wr0, in0, in1, col;
  logic [IDX_W-1:0]      idx0, idx1;
  logic [DATA_WIDTH-1:0] old0, old1, merged, rdata1;

  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      state <= (SCRUB_EN != 0) ? S_SCRUB : S_READY;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      S_SCRUB: begin
        ptr_nxt = ptr + PTR_W'(1);
        if (ptr == LAST_PTR) state_nxt = S_READY;
      end
      default: ;
    endcase
  end

  assign bus.busy = (state == S_SCRUB);
  assign active   = (state == S_READY);

  assign in0  = ({1'b0, bus.addr0} < DEPTH_LIM);
  assign in1  = ({1'b0, bus.addr1} < DEPTH_LIM);
  assign idx0 = bus.addr0[IDX_W-1:0];
  assign idx1 = bus.addr1[IDX_W-1:0];
  assign old0 = in0 ? mem[idx0] : '0;
  assign old1 = in1 ? mem[idx1] : '0;

  assign rd0 = active && !bus.csb0 && bus.web0;
  assign wr0 = active && !bus.csb0 && !bus.web0;
  assign rd1 = active && !bus.csb1;
  assign col = wr0 && rd1 && in0 && (bus.addr0 == bus.addr1);

  always_comb begin
    merged = old0;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (bus.wmask0[i]) merged[i*WMASK_WIDTH +: WMASK_WIDTH] = bus.din0[i*WMASK_WIDTH +: WMASK_WIDTH];
    end
  end

  assign rdata1 = (col && (COLLISION_MODE == 1)) ? merged : old1;

  // The array has no reset; while rst is held the FSM sits at scrub word 0,
  // which the scrub rewrites after release anyway.
  always_ff @(posedge clk0) begin
    if (state == S_SCRUB) begin
      mem[ptr[IDX_W-1:0]] <= INIT_VALUE;
    end else if (wr0 && in0) begin
      mem[idx0] <= merged;
    end
  end

  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) bus.collision <= 1'b0;
    else     bus.collision <= col;
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s1_v0, s1_v1;
      logic [DATA_WIDTH-1:0] s1_d0, s1_d1;

      always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
          s1_v0     <= 1'b0;
          s1_v1     <= 1'b0;
          s1_d0     <= '0;
          s1_d1     <= '0;
          bus.dout0 <= '0;
          bus.dout1 <= '0;
        end else begin
          s1_v0 <= rd0;
          s1_v1 <= rd1;
          if (rd0)   s1_d0     <= old0;
          if (rd1)   s1_d1     <= rdata1;
          if (s1_v0) bus.dout0 <= s1_d0;
          if (s1_v1) bus.dout1 <= s1_d1;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
          bus.dout0 <= '0;
          bus.dout1 <= '0;
        end else begin
          if (rd0) bus.dout0 <= old0;
          if (rd1) bus.dout1 <= rdata1;
        end
      end
    end
  endgenerate
endmodule
`default_nettype wire
